trace_monitor: RTL and testbench

TRACE_MONITOR -- requirements
Module: trace_monitor

---
 rtl/trace_monitor.sv | 129 ++++++++++++
 tb/tb_trace_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_monitor.sv
// trace_monitor: run-time trace of core write-backs into a show-ahead FIFO,
// with cycle/retire counters and halt or cycle-budget run termination.
module trace_monitor #(
   parameter int DATA_W      = 32,
   parameter int AW          = 5,
   parameter int DEPTH       = 16,
   parameter int MAX_CYCLES  = 1024,
   parameter int HALT_REPEAT = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [DATA_W-1:0]        i_pc,
   input  logic [DATA_W-1:0]        i_halt_pc,
   input  logic                     i_wb_en,
   input  logic [AW-1:0]            i_wb_addr,
   input  logic [DATA_W-1:0]        i_wb_data,
   input  logic                     i_ovf,
   output logic                     o_rd_valid,
   input  logic                     i_rd_ready,
   output logic [DATA_W-1:0]        o_rd_pc,
   output logic [AW-1:0]            o_rd_addr,
   output logic [DATA_W-1:0]        o_rd_data,
   output logic                     o_rd_ovf,
   output logic [1:0]               o_state,
   output logic                     o_done,
   output logic                     o_timeout,
   output logic [31:0]              o_cycle_cnt,
   output logic [31:0]              o_retire_cnt,
   output logic [15:0]              o_dropped,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = 2*DATA_W + AW + 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [31:0]       r_cycle_cnt, r_retire_cnt, r_halt_cnt;
   logic [15:0]       r_dropped;
   logic              r_timeout, r_first;
   logic [DATA_W-1:0] r_prev_pc;
   logic [EW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW:0]       r_level;

   logic          w_run, w_clear, w_pop, w_push, w_full, w_wr, w_drop, w_ret, w_halt, w_tmo;
   logic [PW:0]   w_level_nxt;
   logic [31:0]   w_halt_nxt, w_cyc_nxt;
   logic [EW-1:0] w_head;

   assign w_run       = r_state == S_RUN;
   assign w_clear     = i_start && (r_state == S_IDLE || r_state == S_DONE);
   assign o_rd_valid  = r_level != '0;
   assign w_pop       = o_rd_valid && i_rd_ready;
   assign w_push      = w_run && i_wb_en && (i_wb_addr != '0);
   assign w_full      = r_level == (PW+1)'(DEPTH);
   // A full FIFO still accepts a push when the head leaves on the same edge
   assign w_wr        = w_push && (!w_full || w_pop);
   assign w_drop      = w_push && w_full && !w_pop;
   assign w_level_nxt = r_level + {{PW{1'b0}}, w_wr} - {{PW{1'b0}}, w_pop};
   assign w_ret       = r_first || (i_pc != r_prev_pc);
   assign w_halt_nxt  = (i_pc == i_halt_pc) ? r_halt_cnt + 32'd1 : '0;
   assign w_halt      = w_halt_nxt >= 32'(HALT_REPEAT);
   assign w_cyc_nxt   = r_cycle_cnt + 32'd1;
   assign w_tmo       = w_cyc_nxt == 32'(MAX_CYCLES);

   // Head is masked when empty so stale memory never leaks onto rd_*
   assign w_head = r_mem[r_rd_ptr];
   assign {o_rd_pc, o_rd_addr, o_rd_data, o_rd_ovf} = o_rd_valid ? w_head : '0;

   assign o_state      = r_state;
   assign o_done       = r_state == S_DONE;
   assign o_timeout    = r_timeout;
   assign o_cycle_cnt  = r_cycle_cnt;
   assign o_retire_cnt = r_retire_cnt;
   assign o_dropped    = r_dropped;
   assign o_level      = r_level;

   always_ff @(posedge i_clk)
      if (w_wr) r_mem[r_wr_ptr] <= {i_pc, i_wb_addr, i_wb_data, i_ovf};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
         r_halt_cnt   <= '0;
         r_dropped    <= '0;
         r_timeout    <= 1'b0;
         r_first      <= 1'b0;
         r_prev_pc    <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
      end else begin
         r_prev_pc <= i_pc;
         if (w_clear) begin
            r_state      <= S_RUN;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_halt_cnt   <= '0;
            r_dropped    <= '0;
            r_timeout    <= 1'b0;
            r_first      <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
         end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            if (w_run) begin
               r_first      <= 1'b0;
               r_cycle_cnt  <= w_cyc_nxt;
               r_retire_cnt <= r_retire_cnt + {31'd0, w_ret};
               r_halt_cnt   <= w_halt_nxt;
               if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
               // Halt takes priority over budget exhaustion on the same edge
               if (w_halt || w_tmo) begin
                  r_state   <= S_DRAIN;
                  r_timeout <= !w_halt;
               end
            end else if (r_state == S_DRAIN && w_level_nxt == '0) begin
               r_state <= S_DONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_trace_monitor.sv
// tb_trace_monitor: scoreboard bench; a queue-based reference model predicts
// every trace entry and counter, a negedge monitor checks each popped entry.
module tb_trace_monitor;
   localparam int DW = 32, AW = 5, DEPTH = 4, MAXC = 8, HR = 2;

   logic          clk = 1'b0, rst_n, start, wb_en, ovf, rd_ready;
   logic [DW-1:0] pc, halt_pc, wb_data;
   logic [AW-1:0] wb_addr;
   logic          o_rd_valid, o_rd_ovf, o_done, o_timeout;
   logic [DW-1:0] o_rd_pc, o_rd_data;
   logic [AW-1:0] o_rd_addr;
   logic [1:0]    o_state;
   logic [31:0]   o_cycle_cnt, o_retire_cnt;
   logic [15:0]   o_dropped;
   logic [2:0]    o_level;

   trace_monitor #(.DATA_W(DW), .AW(AW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_REPEAT(HR)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pc(pc), .i_halt_pc(halt_pc),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_ovf(ovf),
      .o_rd_valid(o_rd_valid), .i_rd_ready(rd_ready), .o_rd_pc(o_rd_pc), .o_rd_addr(o_rd_addr),
      .o_rd_data(o_rd_data), .o_rd_ovf(o_rd_ovf), .o_state(o_state), .o_done(o_done),
      .o_timeout(o_timeout), .o_cycle_cnt(o_cycle_cnt), .o_retire_cnt(o_retire_cnt),
      .o_dropped(o_dropped), .o_level(o_level)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   logic [69:0] exp_q[$];
   logic [69:0] mon_e;

   int      m_state, m_cyc, m_ret, m_drop, m_halt, m_level;
   bit      m_to, m_first;
   logic [DW-1:0] m_prev;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
   endtask

   // Every handshake must present exactly the oldest predicted entry
   always @(negedge clk)
      if (rst_n && o_rd_valid && rd_ready) begin
         if (exp_q.size() == 0) chk("pop_with_empty_scoreboard", 64'd1, 64'd0);
         else begin
            mon_e = exp_q.pop_front();
            chk("rd_pc", 64'(o_rd_pc), 64'(mon_e[69:38]));
            chk("rd_addr", 64'(o_rd_addr), 64'(mon_e[37:33]));
            chk("rd_data", 64'(o_rd_data), 64'(mon_e[32:1]));
            chk("rd_ovf", 64'(o_rd_ovf), 64'(mon_e[0]));
         end
      end

   task automatic model_reset();
      m_state = 0; m_cyc = 0; m_ret = 0; m_drop = 0; m_halt = 0; m_level = 0;
      m_to = 0; m_first = 0; m_prev = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit pop;
      pop = (m_level > 0) && rd_ready;
      if (m_state == 0 || m_state == 3) begin
         if (start) begin
            m_state = 1; m_cyc = 0; m_ret = 0; m_drop = 0; m_to = 0; m_halt = 0; m_first = 1;
         end
      end else if (m_state == 1) begin
         m_cyc++;
         if (m_first || pc != m_prev) m_ret++;
         m_first = 0;
         m_halt = (pc == halt_pc) ? m_halt + 1 : 0;
         if (wb_en && wb_addr != 0) begin
            if (m_level < DEPTH || pop) begin
               exp_q.push_back({pc, wb_addr, wb_data, ovf});
               m_level++;
            end else if (m_drop < 65535) m_drop++;
         end
         if (pop) m_level--;
         if (m_halt >= HR) begin m_state = 2; m_to = 0; end
         else if (m_cyc == MAXC) begin m_state = 2; m_to = 1; end
      end else begin
         if (pop) m_level--;
         if (m_level == 0) m_state = 3;
      end
      m_prev = pc;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("state", 64'(o_state), 64'(m_state));
      chk("level", 64'(o_level), 64'(m_level));
      chk("rd_valid", 64'(o_rd_valid), 64'(m_level != 0));
      chk("cycle_cnt", 64'(o_cycle_cnt), 64'(m_cyc));
      chk("retire_cnt", 64'(o_retire_cnt), 64'(m_ret));
      chk("dropped", 64'(o_dropped), 64'(m_drop));
      chk("timeout", 64'(o_timeout), 64'(m_to));
      chk("done", 64'(o_done), 64'(m_state == 3));
   endtask

   task automatic drive(input logic [DW-1:0] p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pc = p; wb_en = we; wb_addr = a; wb_data = d; ovf = $urandom_range(0, 1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, 64'(o_state), 64'd0);
      chk({tag, "_level"}, 64'(o_level), 64'd0);
      chk({tag, "_rd_valid"}, 64'(o_rd_valid), 64'd0);
      chk({tag, "_rd_fields"}, 64'({o_rd_pc, o_rd_addr, o_rd_data[26:0], o_rd_ovf} != 0), 64'd0);
      chk({tag, "_counters"}, 64'(o_cycle_cnt | o_retire_cnt | 32'(o_dropped)), 64'd0);
      chk({tag, "_done_timeout"}, 64'({o_done, o_timeout}), 64'd0);
   endtask

   // Asynchronous reset applied away from any clock edge
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_reset_values(tag);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_to_done();
      for (int i = 0; i < 20 && m_state != 3; i++) step();
      chk("reached_done", 64'(o_done), 64'd1);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 0; rd_ready = 0; halt_pc = 32'hC;
      drive(32'h0, 0, 0, 0);
      model_reset();
      #3 check_reset_values("por");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic halt run: x8/x9 logged, x0 write ignored
      rd_ready = 1; start = 1; step(); start = 0;
      drive(32'h0, 1, 5'd8, 32'h5); step();
      drive(32'h4, 1, 5'd9, 32'hA); step();
      drive(32'h8, 1, 5'd0, 32'h7); step();
      drive(32'hC, 0, 0, 0); step(); step();
      chk("halt_state_drain", 64'(o_state), 64'd2);
      chk("halt_retire_4", 64'(o_retire_cnt), 64'd4);
      chk("halt_timeout_0", 64'(o_timeout), 64'd0);
      run_to_done();

      // Restart from DONE: second run reports only its own statistics
      start = 1; step(); start = 0;
      chk("restart_cyc_clear", 64'(o_cycle_cnt), 64'd0);
      drive(32'h20, 0, 0, 0); step();
      drive(32'hC, 0, 0, 0); step(); step();
      chk("run2_retire", 64'(o_retire_cnt), 64'd2);
      chk("run2_cycles", 64'(o_cycle_cnt), 64'd3);
      run_to_done();

      // Overflow, full push+pop, then budget timeout
      rd_ready = 0; start = 1; step(); start = 0;
      for (int i = 0; i < 6; i++) begin
         drive(32'h100 + 32'(4*i), 1, 5'(i + 1), $urandom); step();
      end
      chk("ovf_level_full", 64'(o_level), 64'd4);
      chk("ovf_dropped_2", 64'(o_dropped), 64'd2);
      rd_ready = 1; drive(32'h200, 1, 5'd7, $urandom); step();
      chk("fullpp_level", 64'(o_level), 64'd4);
      chk("fullpp_dropped", 64'(o_dropped), 64'd2);
      drive(32'h204, 0, 0, 0); step();
      chk("tmo_cycles", 64'(o_cycle_cnt), 64'd8);
      chk("tmo_flag", 64'(o_timeout), 64'd1);
      chk("tmo_state", 64'(o_state), 64'd2);
      run_to_done();

      // Halt reached on the budget edge: halt wins
      start = 1; step(); start = 0;
      drive(32'h40, 0, 0, 0);
      for (int i = 0; i < 6; i++) step();
      drive(32'hC, 0, 0, 0); step(); step();
      chk("tie_cycles", 64'(o_cycle_cnt), 64'd8);
      chk("tie_timeout_0", 64'(o_timeout), 64'd0);
      run_to_done();

      // Reset mid-run with three entries queued
      rd_ready = 0; start = 1; step(); start = 0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h60 + 32'(4*i), 1, 5'(i + 3), $urandom); step();
      end
      chk("pre_reset_level", 64'(o_level), 64'd3);
      do_reset("midrun");
      chk("post_reset_idle", 64'(o_state), 64'd0);
      rd_ready = 1; start = 1; step(); start = 0;
      drive(32'hC, 0, 0, 0); step(); step();
      chk("clean_retire", 64'(o_retire_cnt), 64'd1);
      run_to_done();

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         start = ($urandom_range(0, 3) == 0);
         rd_ready = $urandom_range(0, 1);
         drive(32'(4 * $urandom_range(0, 4)), $urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom);
         if (c % 97 == 96) do_reset("rand");
         else step();
      end
      start = 0; rd_ready = 1;
      for (int i = 0; i < 30 && (m_state == 1 || m_state == 2); i++) step();
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
